// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
    typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

    localparam int PWM_WIDTH_DEF    = 8;
    localparam int PWM_CHANNELS_DEF = 4;

endpackage

// File: rtl/pwm_multi_if.sv
// Control and output bundle between register logic and the PWM block.
interface pwm_multi_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic                      en;
    logic                      mode;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS-1:0]       duty_wr;
    logic [CHANNELS-1:0]       PWM_sig;
    logic                      period_start;

    modport master (
        output en, mode, period, duty, duty_wr,
        input  PWM_sig, period_start
    );

    modport slave (
        input  en, mode, period, duty, duty_wr,
        output PWM_sig, period_start
    );
endinterface

// File: rtl/pwm_chan.sv
// One PWM channel: double-buffered duty, compare against the shared counter,
// registered output.
module pwm_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    input  logic             duty_wr,
    output logic             pwm
);

    logic [WIDTH-1:0] d_p;
    logic [WIDTH-1:0] d_a;
    logic             pwm_p1;

    // stage p0: pending/active duty; a strobe on a load cycle writes through
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_p <= '0;
            d_a <= '0;
        end else begin
            if (duty_wr) d_p <= duty;
            if (load)    d_a <= duty_wr ? duty : d_p;
        end
    end

    // stage p1: registered compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_p1 <= 1'b0;
        else     pwm_p1 <= en & (cnt < d_a);
    end

    assign pwm = pwm_p1;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter (edge or center aligned)
// feeding CHANNELS independent compare channels.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH_DEF,
    parameter int CHANNELS = PWM_CHANNELS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    pwm_multi_if.slave   bus
);

    logic [WIDTH-1:0]    cnt_p0;
    logic [WIDTH-1:0]    cnt_nxt;
    pwm_dir_e            dir_p0;
    pwm_dir_e            dir_nxt;
    logic [WIDTH-1:0]    p_a;
    pwm_mode_e           m_a;
    logic                wrap;
    logic                load;
    logic                start_p1;
    logic [CHANNELS-1:0] pwm_p1;

    // Wrap detection and next counter value for the active period/mode.
    always_comb begin
        wrap    = 1'b0;
        cnt_nxt = cnt_p0;
        dir_nxt = dir_p0;
        if (p_a == '0) begin
            wrap = 1'b1;
        end else if (m_a == PWM_EDGE) begin
            wrap    = (cnt_p0 == p_a);
            cnt_nxt = cnt_p0 + WIDTH'(1);
        end else if (dir_p0 == DIR_DOWN) begin
            wrap    = (cnt_p0 == WIDTH'(1));
            cnt_nxt = cnt_p0 - WIDTH'(1);
        end else if (cnt_p0 == p_a) begin
            // top of the triangle; with P=1 there is no down leg at all
            wrap    = (p_a <= WIDTH'(1));
            dir_nxt = DIR_DOWN;
            cnt_nxt = cnt_p0 - WIDTH'(1);
        end else begin
            cnt_nxt = cnt_p0 + WIDTH'(1);
        end
    end

    // While disabled everything loads transparently, like a permanent wrap.
    assign load = ~bus.en | wrap;

    // stage p0: shared counter, direction, active period and mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0 <= '0;
            dir_p0 <= DIR_UP;
            p_a    <= '0;
            m_a    <= PWM_EDGE;
        end else if (load) begin
            cnt_p0 <= '0;
            dir_p0 <= DIR_UP;
            p_a    <= bus.period;
            m_a    <= pwm_mode_e'(bus.mode);
        end else begin
            cnt_p0 <= cnt_nxt;
            dir_p0 <= dir_nxt;
        end
    end

    // stage p1: period start marker, aligned with the channel outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) start_p1 <= 1'b0;
        else     start_p1 <= bus.en & (cnt_p0 == '0);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pwm_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .load    (load),
            .cnt     (cnt_p0),
            .duty    (bus.duty[g*WIDTH +: WIDTH]),
            .duty_wr (bus.duty_wr[g]),
            .pwm     (pwm_p1[g])
        );
    end

    assign bus.PWM_sig      = pwm_p1;
    assign bus.period_start = start_p1;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: edge/center modes, duty buffering, period
// change at boundary, asynchronous reset and enable.
module tb_pwm_multi;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    pwm_multi_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    pwm_multi #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived schedule of active duty per channel versus output sample j.
    function automatic int exp_duty(input int ch, input int j);
        case (ch)
            0:       return 3;
            1:       return (j < 20) ? 2 : (j < 30) ? 7 : 4;
            2:       return (j < 40) ? 0 : 2;
            default: return 10;
        endcase
    endfunction

    // Counter value seen by sample j: edge P=9 up to j=39, then center P=4.
    function automatic int exp_cnt(input int j);
        int k;
        if (j < 40) return j % 10;
        k = (j - 40) % 8;
        return (k <= 4) ? k : 8 - k;
    endfunction

    initial begin
        logic [CHANNELS-1:0] exp_pwm;
        n_chk = 0;
        n_err = 0;

        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.mode    = 1'b0;
        bus.period  = 8'd9;
        bus.duty    = {8'd10, 8'd0, 8'd2, 8'd3};
        bus.duty_wr = 4'hF;

        tick();
        chk_eq("rst_pwm", 32'(bus.PWM_sig), 32'h0);
        chk_eq("rst_ps", 32'(bus.period_start), 32'h0);
        rst = 1'b0;

        // en=0 cycle loads period, mode and write-through duties
        tick();
        chk_eq("dis_pwm", 32'(bus.PWM_sig), 32'h0);
        chk_eq("dis_ps", 32'(bus.period_start), 32'h0);
        bus.duty_wr = '0;
        bus.en      = 1'b1;

        for (int j = 0; j < 58; j++) begin
            tick();
            for (int ch = 0; ch < CHANNELS; ch++)
                exp_pwm[ch] = (exp_cnt(j) < exp_duty(ch, j));
            for (int ch = 0; ch < CHANNELS; ch++)
                chk_eq($sformatf("pwm%0d_j%0d", ch, j), 32'(bus.PWM_sig[ch]), 32'(exp_pwm[ch]));
            chk_eq($sformatf("ps_j%0d", j), 32'(bus.period_start), 32'(exp_cnt(j) == 0));

            bus.duty_wr = '0;
            if (j == 14) begin
                bus.duty[1*WIDTH +: WIDTH] = 8'd7;
                bus.duty_wr = 4'b0010;
            end else if (j == 28) begin
                bus.duty[1*WIDTH +: WIDTH] = 8'd4;
                bus.duty_wr = 4'b0010;
            end else if (j == 34) begin
                bus.duty[2*WIDTH +: WIDTH] = 8'd2;
                bus.duty_wr = 4'b0100;
                bus.period  = 8'd4;
                bus.mode    = 1'b1;
            end
        end

        // all outputs are high here; reset must clear them without a clock
        rst = 1'b1;
        #1;
        chk_eq("arst_pwm", 32'(bus.PWM_sig), 32'h0);
        chk_eq("arst_ps", 32'(bus.period_start), 32'h0);
        #2;
        rst = 1'b0;

        for (int t = 0; t < 10; t++) begin
            tick();
            chk_eq($sformatf("post_pwm_t%0d", t), 32'(bus.PWM_sig), 32'h0);
            chk_eq($sformatf("post_ps_t%0d", t), 32'(bus.period_start),
                   32'(t == 0 || t == 1 || t == 9));
        end

        bus.en = 1'b0;
        tick();
        chk_eq("en_off_pwm", 32'(bus.PWM_sig), 32'h0);
        chk_eq("en_off_ps", 32'(bus.period_start), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator: one shared period counter drives CHANNELS independent compare outputs. Each channel has a double-buffered duty register, so updates never glitch mid-period. Edge-aligned and center-aligned modes are supported, and period is programmable at run time. It sits between the control/register logic and the output pins, replacing the fixed 8-bit single-channel PWM.

## Interface
- WIDTH, 8: counter, period and duty width in bits (≥2).
- CHANNELS, 4: number of PWM outputs (≥1).

- clk  in  1: system clock.
- rst  in  1: asynchronous active-high reset.
- en  in  1: run enable; low holds the counter and forces outputs low.
- mode  in  1: 0 = edge-aligned, 1 = center-aligned; sampled at period boundary.
- period  in  WIDTH: period count P; sampled at period boundary.
- duty  in  CHANNELS*WIDTH: packed duty values; channel i occupies bits [i*WIDTH +: WIDTH].
- duty_wr  in  CHANNELS: per-channel write strobe for duty.
- PWM_sig  out  CHANNELS: registered PWM outputs.
- period_start  out  1: one-cycle pulse aligned with the first output cycle of each period.

## Operation
- State held:
  - cnt (WIDTH bits) and dir (up/down);
  - active period and mode (P_a, M_a);
  - per channel: pending duty D_p[i] and active duty D_a[i].
- Duty write: when duty_wr[i]=1, D_p[i] takes the new duty value on the next clk.
- Edge mode counter: 0,1,…,P_a, then 0. Period is P_a+1 cycles.
- Center mode counter:
  - counts up 0→P_a, then down P_a−1→1, then 0.
  - Period is 2·P_a cycles; P_a=1 gives 0,1,0,1.
- P_a=0: cnt stays 0 in both modes, and every cycle is a wrap.
- Wrap cycle (next cnt is 0 and a new period starts), while en=1:
  - edge mode: cnt==P_a;
  - center mode: (dir=down and cnt==1) or (dir=up and cnt==P_a and P_a≤1).
- On a wrap cycle:
  - P_a←period, M_a←mode, dir←up.
  - D_a[i]←(duty_wr[i] ? new duty : D_p[i]), so a write on the wrap cycle takes effect immediately.
- Compare: raw[i] = (cnt < D_a[i]), unsigned.
  - D_a=0 gives constant low.
  - D_a>P_a (edge) or D_a>P_a (center) gives constant high.
  - High time per period: D_a cycles in edge mode, 2·D_a−1 cycles in center mode (for 0<D_a≤P_a).
- en=0:
  - cnt←0, dir←up.
  - P_a, M_a and D_a track their inputs every cycle (transparent load), with D_a taking the write-through value.
  - PWM_sig←0, period_start←0.
- en 0→1: the first cycle with en=1 evaluates cnt=0, which is period start.
- Mode or period changes between boundaries are ignored until the next wrap.

## Timing
- Reset values:
  - cnt=0, dir=up, P_a=0, M_a=edge;
  - all D_p and D_a = 0;
  - PWM_sig=0, period_start=0.
- Latency: PWM_sig[i] at clock edge k+1 reflects en·raw[i] evaluated with cnt at cycle k, i.e. one registered stage.
- period_start is registered with the same alignment: it is 1 in the cycle where PWM_sig reflects cnt=0 with en=1.
- Duty write to visible effect: the write is taken at the next wrap, then the one-cycle output latency applies. It is never visible mid-period.
- Reset asserted mid-period: all state returns to reset values asynchronously. After release, the block restarts from cnt=0 with zero duty.
- Simultaneous duty_wr on several channels: each channel is independent, with no priority.

## Structure
- Package pwm_pkg:
  - typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
  - default-width localparams.
- Top pwm_multi holds the shared counter, direction, active period/mode and wrap logic.
- Sub-module pwm_chan holds D_p, D_a, the compare and the output flop for one channel. It is instantiated CHANNELS times via generate and takes cnt, wrap, en and its duty slice and strobe.

## Test plan
- Edge mode, WIDTH=8, P=9, duty[0]=3, en=1 → PWM_sig[0] high 3 of every 10 cycles; period_start every 10 cycles coincident with the rising edge of PWM_sig[0].
- duty 0 and duty 10 with P=9 → channel stays low, and channel stays high for all cycles.
- Write duty[1]=7 mid-period (old value 2) → current period shows 2 high cycles; the next period shows 7. A write on the wrap cycle applies immediately.
- Center mode, P=4, duty=2 → counter sequence 0,1,2,3,4,3,2,1; output high 3 of 8 cycles, symmetric about cnt=0.
- Change period 9→4 and mode mid-period → the current period completes at P=9 in edge mode, and the new settings apply from the next period.
- Assert rst mid-period with outputs high → PWM_sig=0 immediately. After release with en=1 and no writes, outputs stay low.
